clk_div_multi: RTL
==================

// Module: clk_div_multi
// PURPOSE
//  Parametrised N-channel clock-enable generator. Derives per-channel divided clock-enables and
//  square waves from the 50 MHz board clock; successor to the fixed 50->3 MHz DCM path.
//  Divide ratios are runtime-programmable, with glitch-free switching and a per-channel lock flag.
//  Sits beside the clock primitive and feeds slow-domain logic (UART, PWM, scan) as enables, not clocks.
// PARAMETERS
//  CHANNELS     4    number of independent divider channels (1..16)
//  DIV_W        16   width of divide-ratio field
//  DEFAULT_DIV  16   ratio loaded at reset (50 MHz / 16 = 3.125 MHz)
//  LOCK_CYCLES  4    full output periods at new ratio before locked asserts (>=1)
// PORTS
//  clk        in   1                   system clock, 50 MHz
//  rst_n      in   1                   asynchronous reset, active low
//  ch_en      in   CHANNELS            per-channel run enable (level)
//  cfg_valid  in   1                   ratio-write request
//  cfg_ready  out  1                   ratio-write accept
//  cfg_ch     in   $clog2(CHANNELS)    target channel (must be < CHANNELS; >= CHANNELS: write dropped)
//  cfg_div    in   DIV_W               new divide ratio N
//  clk_ce     out  CHANNELS            1-cycle pulse once per period
//  clk_sq     out  CHANNELS            ~50% square wave
//  locked     out  CHANNELS            channel running at stable ratio
//  sync_in    in   1                   phase realign strobe (only with CLKDIV_SYNC_EN)
// BEHAVIOUR
//  - One clock domain; reset async assert, sync deassert expected from upstream. All outputs registered.
//  - Reset: cnt=0, div=DEFAULT_DIV, pending=0, state=OFF; clk_ce=0, clk_sq=0, locked=0, cfg_ready=1.
//  - Ratio clamp: N<2 stored as 2. Counter runs 0..N-1 and wraps.
//  - clk_ce=1 for the single cycle where cnt==N-1. clk_sq=1 for cnt < ceil(N/2) (N=5: 3 high, 2 low).
//  - Config handshake: write on cfg_valid&&cfg_ready. cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
//    Accepted value stored in pend_div, pending set. Channel OFF: applied next cycle (pending clears).
//    Running: applied on the wrap cycle (cnt==N-1); the next period uses the new N; no truncated period.
//  - Per-channel FSM (states in package):
//    OFF    : ch_en=0; cnt held 0, clk_ce=clk_sq=locked=0. ch_en=1 -> SETTLE, cnt starts 0 (clk_sq high next cycle).
//    SETTLE : periods counted by a settle counter; after LOCK_CYCLES wraps -> LOCKED.
//    LOCKED : locked=1. Ratio applied -> SETTLE (locked drops in cycle after wrap), settle counter cleared.
//    Any state: ch_en=0 -> OFF next cycle, outputs 0 next cycle; in-progress period discarded.
//  - Simultaneous wrap + accepted write to same channel: value from this cycle accepted into
//    pend_div, applied at the FOLLOWING wrap (not this one).
//  - Channels are independent; writes to one channel never perturb another channel's cnt.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined: sync_in port present. sync_in=1 sets cnt=0 on every channel in SETTLE or
//    LOCKED next cycle; no clk_ce for the truncated period; locked unaffected; pending ratio applied at
//    sync if present (sync counts as a wrap). sync coincident with wrap: sync wins, no clk_ce.
//  Not defined: no sync_in port; phases only set by ch_en rising edge.
// STRUCTURE
//  clkdiv_pkg: state enum {OFF,SETTLE,LOCKED}, localparam MIN_DIV=2, clamp function.
//  clkdiv_chan: one channel (counter, pend_div, FSM, outputs); top generates CHANNELS instances
//    and decodes cfg_ch/cfg_ready.
// TESTING
//  1 Reset, ch_en=4'b0001, default N=16 -> clk_ce[0] every 16 clks, clk_sq[0] 8 high/8 low;
//    locked[0] rises after 4 periods (64 clks); channels 1-3 stay 0.
//  2 ch1 running N=16, write cfg_div=5 mid-period -> current period completes at 16, then 5-clk
//    periods (3 high/2 low); locked[1] low for 4x5 clks then high; second write stalls (cfg_ready=0) until apply.
//  3 cfg_div=0 and 1 -> behaves as N=2 (clk_ce every 2 clks, clk_sq alternating).
//  4 Drop ch_en[2] mid-period, rst_n low mid-operation -> outputs 0 next cycle / immediately;
//    re-enable restarts phase at cnt=0.
//  5 (CLKDIV_SYNC_EN) ch0 N=16, ch1 N=8, pulse sync_in -> both cnt=0 next cycle, no clk_ce for cut
//    period, clk_ce edges aligned thereafter every 16 clks; locked unchanged.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clk_div_multi clock-enable generator.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } chan_state_e;

  localparam int unsigned MIN_DIV = 2;

  // Ratios below MIN_DIV cannot produce a distinct high and low phase.
  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < MIN_DIV) ? MIN_DIV : n;
  endfunction

  // High-phase length ceil(n/2), computed without an n+1 overflow at full width.
  function automatic int unsigned high_len(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Ratio-write handshake bundle for clk_div_multi: valid/ready plus channel index and divide ratio.
interface clk_div_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 16
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, staged ratio, OFF/SETTLE/LOCKED FSM and registered outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 16,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             ce,
  output logic             sq,
  output logic             locked
);

  localparam int unsigned      SET_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(DEFAULT_DIV));

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             ce_q, ce_d;
  logic             sq_q, sq_d;
  logic             locked_q, locked_d;
  logic             wrap;
  logic             apply;
  logic             run_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    settle_d   = settle_q;
    apply      = 1'b0;
    wrap       = (cnt_q == div_q - DIV_W'(1));

    case (state_q)
      ST_OFF: begin
        cnt_d    = '0;
        settle_d = '0;
        apply    = pending_q;
        if (en) state_d = ST_SETTLE;
      end
      default: begin
        if (!en) begin
          state_d  = ST_OFF;
          cnt_d    = '0;
          settle_d = '0;
        end else if (sync || wrap) begin
          // A sync restart is treated like a wrap for ratio updates, but only
          // genuine wraps advance the settle count.
          cnt_d = '0;
          if (pending_q) begin
            apply    = 1'b1;
            state_d  = ST_SETTLE;
            settle_d = '0;
          end else if (wrap && state_q == ST_SETTLE) begin
            if (int'(settle_q) + 1 >= int'(LOCK_CYCLES)) state_d = ST_LOCKED;
            else                                        settle_d = settle_q + SET_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
    endcase

    if (apply) begin
      div_d     = pend_div_q;
      pending_d = 1'b0;
    end
    // wr is only granted while nothing is pending, so it never collides with apply.
    if (wr) begin
      pend_div_d = DIV_W'(clamp_div(int'(wr_div)));
      pending_d  = 1'b1;
    end

    run_d    = (state_d != ST_OFF);
    ce_d     = run_d && (cnt_d == div_d - DIV_W'(1));
    sq_d     = run_d && (cnt_d < DIV_W'(high_len(int'(div_d))));
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_div_q <= RST_DIV;
      pending_q  <= 1'b0;
      settle_q   <= '0;
      ce_q       <= 1'b0;
      sq_q       <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      settle_q   <= settle_d;
      ce_q       <= ce_d;
      sq_q       <= sq_d;
      locked_q   <= locked_d;
    end
  end

  assign pending = pending_q;
  assign ce      = ce_q;
  assign sq      = sq_q;
  assign locked  = locked_q;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel clock-enable generator with runtime-programmable ratios and per-channel lock flags.
// Optional CLKDIV_SYNC_EN adds the sync_in phase-realign strobe.
module clk_div_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 16,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  clk_div_multi_if.slave      cfg,
  output logic [CHANNELS-1:0] clk_ce,
  output logic [CHANNELS-1:0] clk_sq,
  output logic [CHANNELS-1:0] locked
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic                sync_in
`endif
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SEL_N = 1 << CH_W;

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] wr;
  logic [SEL_N-1:0]    busy;
  logic                sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Unused channel codes read as idle, so a write to them is accepted and dropped.
  always_comb begin
    busy                 = '0;
    busy[CHANNELS-1:0]   = pending;
    cfg.cfg_ready        = ~busy[cfg.cfg_ch];
  end

  always_comb begin
    wr = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr[i] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg.cfg_div),
      .pending (pending[g]),
      .ce      (clk_ce[g]),
      .sq      (clk_sq[g]),
      .locked  (locked[g])
    );
  end

endmodule
